// File: rtl/cmp_stream_if.sv
// Operand/result bundle for the streaming comparator: operand pair and mode in,
// registered compare result and running statistics out.
interface cmp_stream_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic             clr;
    logic             out_valid;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [WIDTH-1:0] max_val;
    logic             max_ok;
    logic [CNT_W-1:0] gt_cnt;

    modport master (
        output in_valid, a, b, sgn, clr,
        input  out_valid, gt, eq, lt, max_val, max_ok, gt_cnt
    );

    modport slave (
        input  in_valid, a, b, sgn, clr,
        output out_valid, gt, eq, lt, max_val, max_ok, gt_cnt
    );
endinterface

// File: rtl/cmp_stream.sv
// One-pair-per-cycle signed/unsigned comparator with registered result,
// saturating greater-than counter and running maximum of operand A.
module cmp_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    cmp_stream_if.slave  bus
);
    logic             out_valid_reg;
    logic             gt_reg;
    logic             eq_reg;
    logic             lt_reg;
    logic [WIDTH-1:0] max_val_reg;
    logic             max_ok_reg;
    logic [CNT_W-1:0] gt_cnt_reg;

    logic [WIDTH-1:0] max_val_next;
    logic             max_ok_next;
    logic [CNT_W-1:0] gt_cnt_next;

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic [WIDTH-1:0] max_key;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_gt_max;

    // Flipping the sign bit in signed mode turns a two's-complement ordering
    // into an unsigned one, so a single magnitude comparator serves both modes.
    always_comb begin
        a_key    = {bus.a[WIDTH-1] ^ bus.sgn, bus.a[WIDTH-2:0]};
        b_key    = {bus.b[WIDTH-1] ^ bus.sgn, bus.b[WIDTH-2:0]};
        max_key  = {max_val_reg[WIDTH-1] ^ bus.sgn, max_val_reg[WIDTH-2:0]};
        a_gt_b   = a_key > b_key;
        a_eq_b   = bus.a == bus.b;
        a_gt_max = a_key > max_key;
    end

    // Clear wipes the old statistics first, so a pair arriving with clr
    // is treated as the first pair of a fresh run.
    always_comb begin
        gt_cnt_next  = bus.clr ? '0 : gt_cnt_reg;
        max_val_next = bus.clr ? '0 : max_val_reg;
        max_ok_next  = bus.clr ? 1'b0 : max_ok_reg;
        if (bus.in_valid) begin
            if (a_gt_b && (gt_cnt_next != {CNT_W{1'b1}})) begin
                gt_cnt_next = gt_cnt_next + CNT_W'(1);
            end
            if (!max_ok_next || a_gt_max) begin
                max_val_next = bus.a;
                max_ok_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            gt_reg        <= 1'b0;
            eq_reg        <= 1'b0;
            lt_reg        <= 1'b0;
            max_val_reg   <= '0;
            max_ok_reg    <= 1'b0;
            gt_cnt_reg    <= '0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                gt_reg <= a_gt_b;
                eq_reg <= a_eq_b;
                lt_reg <= !a_gt_b && !a_eq_b;
            end
            max_val_reg <= max_val_next;
            max_ok_reg  <= max_ok_next;
            gt_cnt_reg  <= gt_cnt_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.gt        = gt_reg;
    assign bus.eq        = eq_reg;
    assign bus.lt        = lt_reg;
    assign bus.max_val   = max_val_reg;
    assign bus.max_ok    = max_ok_reg;
    assign bus.gt_cnt    = gt_cnt_reg;
endmodule

// File: tb/tb_cmp_stream.sv
// Scoreboard bench for cmp_stream: directed pairs push hand-computed results,
// negedge monitors pop and compare whenever out_valid is seen.
module tb_cmp_stream;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmp_stream_if #(.WIDTH(4), .CNT_W(8)) bus ();
    cmp_stream_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

    cmp_stream #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    cmp_stream #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // result packing: {gt, eq, lt, max_ok, max_val[3:0], gt_cnt[7:0]}
    typedef struct {
        string       name;
        logic [15:0] res;
    } exp_t;
    // result packing: {gt, gt_cnt[1:0]}
    typedef struct {
        string      name;
        logic [2:0] res;
    } exp2_t;

    exp_t  exp_q[$];
    exp2_t exp2_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic apply(input string name, input logic [3:0] av, input logic [3:0] bv,
                         input logic s, input logic c,
                         input logic g, input logic e, input logic l,
                         input logic mo, input logic [3:0] mv, input logic [7:0] cnt);
        exp_t x;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.sgn = s;
        bus.clr = c;
        x.name = name;
        x.res = {g, e, l, mo, mv, cnt};
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
    endtask

    task automatic apply2(input string name, input logic [3:0] av, input logic [3:0] bv,
                          input logic g, input logic [1:0] cnt);
        exp2_t x;
        bus2.in_valid = 1'b1;
        bus2.a = av;
        bus2.b = bv;
        bus2.sgn = 1'b0;
        x.name = name;
        x.res = {g, cnt};
        exp2_q.push_back(x);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    task automatic clear_only();
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        if (!reset && bus.out_valid) begin
            act = {bus.gt, bus.eq, bus.lt, bus.max_ok, bus.max_val, bus.gt_cnt};
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got result %h, expected no output", act);
            end else begin
                e = exp_q.pop_front();
                check(e.name, 32'(act), 32'(e.res));
            end
        end
    end

    always @(negedge clk) begin
        exp2_t      e;
        logic [2:0] act;
        if (!reset && bus2.out_valid) begin
            act = {bus2.gt, bus2.gt_cnt};
            if (exp2_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid2: got result %h, expected no output", act);
            end else begin
                e = exp2_q.pop_front();
                check(e.name, 32'(act), 32'(e.res));
            end
        end
    end

    function automatic logic [16:0] all_outs();
        return {bus.out_valid, bus.gt, bus.eq, bus.lt, bus.max_ok, bus.max_val, bus.gt_cnt};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.sgn = 1'b0;  bus.clr = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sgn = 1'b0; bus2.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(all_outs()), 32'd0);
        check("reset_cnt2", 32'(bus2.gt_cnt), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'(all_outs()), 32'd0);

        // signed vs unsigned on the same operands; mode is per pair
        apply("signed_8_vs_7",   4'h8, 4'h7, 1'b1, 1'b0, 0, 0, 1, 1, 4'h8, 8'd0);
        apply("unsigned_8_vs_7", 4'h8, 4'h7, 1'b0, 1'b0, 1, 0, 0, 1, 4'h8, 8'd1);
        @(posedge clk);
        #1;
        clear_only();
        check("clr_stats", 32'({bus.max_ok, bus.max_val, bus.gt_cnt}), 32'd0);
        check("clr_keeps_result", 32'({bus.gt, bus.eq, bus.lt}), 32'b100);

        // back-to-back stream
        apply("stream_eq", 4'd3, 4'd3, 1'b0, 1'b0, 0, 1, 0, 1, 4'd3, 8'd0);
        apply("stream_gt", 4'd5, 4'd2, 1'b0, 1'b0, 1, 0, 0, 1, 4'd5, 8'd1);
        apply("stream_lt", 4'd2, 4'd5, 1'b0, 1'b0, 0, 0, 1, 1, 4'd5, 8'd1);
        @(posedge clk);
        #1;
        check("hold_when_idle", 32'({bus.out_valid, bus.gt, bus.eq, bus.lt}), 32'b0001);

        // build gt_cnt=7, max_val=6, then clear together with a pair
        apply("build_6_0", 4'd6, 4'd0, 1'b0, 1'b0, 1, 0, 0, 1, 4'd6, 8'd2);
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("build_1_0_%0d", i), 4'd1, 4'd0, 1'b0, 1'b0,
                  1, 0, 0, 1, 4'd6, 8'(3 + i));
        end
        apply("clr_with_pair", 4'd2, 4'd1, 1'b0, 1'b1, 1, 0, 0, 1, 4'd2, 8'd1);

        // signed running maximum
        clear_only();
        apply("smax_m8", 4'h8, 4'h0, 1'b1, 1'b0, 0, 0, 1, 1, 4'h8, 8'd0);
        apply("smax_m1", 4'hF, 4'h0, 1'b1, 1'b0, 0, 0, 1, 1, 4'hF, 8'd0);
        apply("smax_p7", 4'h7, 4'h0, 1'b1, 1'b0, 1, 0, 0, 1, 4'h7, 8'd1);
        apply("smax_p3", 4'h3, 4'h0, 1'b1, 1'b0, 1, 0, 0, 1, 4'h7, 8'd2);

        // asynchronous reset in the middle of a stream
        apply("mid_stream", 4'd1, 4'd2, 1'b0, 1'b0, 0, 0, 1, 1, 4'h7, 8'd2);
        bus.in_valid = 1'b1;
        bus.a = 4'd3;
        bus.b = 4'd3;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(all_outs()), 32'd0);
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_valid_after_reset", 32'(all_outs()), 32'd0);
        apply("first_after_reset", 4'd4, 4'd3, 1'b0, 1'b0, 1, 0, 0, 1, 4'd4, 8'd1);

        // saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            apply2($sformatf("sat_%0d", i), 4'd9, 4'd1, 1'b1, (i < 3) ? 2'(i + 1) : 2'd3);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("queue2_drained", 32'(exp2_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
